as_wb_bridge_burst: RTL and testbench

AS_WB_BRIDGE_BURST -- requirements
Module: as_wb_bridge_burst

---
 rtl/as_wb_pkg.sv | 31 +++
 rtl/as_resp_tx.sv | 54 +++++
 rtl/as_wb_bridge_burst.sv | 207 ++++++++++++++++++++
 tb/tb_as_wb_bridge_burst.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/as_wb_pkg.sv
// Shared definitions for the byte-stream to Wishbone burst bridge.
//   cmd_e    : command codes received on the inbound byte stream
//   RSP_*    : response type bytes sent on the outbound byte stream
//   state_e  : bridge controller states
//   is_bus_cmd() : true for the commands that run Wishbone cycles
package as_wb_pkg;

  typedef enum logic [7:0] {
    CMD_NOP         = 8'h00,
    CMD_READ        = 8'h01,
    CMD_WRITE       = 8'h02,
    CMD_BURST_READ  = 8'h03,
    CMD_BURST_WRITE = 8'h04,
    CMD_PING        = 8'h08
  } cmd_e;

  localparam logic [7:0] RSP_ACK      = 8'h01;
  localparam logic [7:0] RSP_PING     = 8'h08;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hFC;
  localparam logic [7:0] RSP_CMDERROR = 8'hFD;
  localparam logic [7:0] RSP_BUSERROR = 8'hFE;

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_COUNT, ST_WDATA, ST_BUS, ST_RESP, ST_DRAIN
  } state_e;

  function automatic logic is_bus_cmd(input logic [7:0] code);
    return (code >= CMD_READ) && (code <= CMD_BURST_WRITE);
  endfunction

endpackage

// File: rtl/as_resp_tx.sv
// Response serialiser: loads a type byte plus an optional DATA_BYTES payload
// and streams them out LSB first under as_busy_i flow control.
// Ports:
//   clk, reset (sync, active-high)
//   load, type_byte, payload, with_payload : start a new response
//   as_data_o, as_dstrb_o, as_busy_i       : outbound byte stream
//   done : pulses on the cycle the final byte transfers
module as_resp_tx #(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [7:0]              type_byte,
  input  logic [8*DATA_BYTES-1:0] payload,
  input  logic                    with_payload,
  output logic [7:0]              as_data_o,
  output logic                    as_dstrb_o,
  input  logic                    as_busy_i,
  output logic                    done
);

  logic [8*DATA_BYTES-1:0] pay_q;
  logic [2:0]              left_q;   // payload bytes still to send after the current one
  logic                    fire;

  assign fire = as_dstrb_o && !as_busy_i;
  assign done = fire && (left_q == 3'd0);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      as_data_o  <= '0;
      as_dstrb_o <= 1'b0;
      pay_q      <= '0;
      left_q     <= '0;
    end else if (load) begin
      as_data_o  <= type_byte;
      as_dstrb_o <= 1'b1;
      pay_q      <= payload;
      left_q     <= with_payload ? 3'(DATA_BYTES) : 3'd0;
    end else if (fire) begin
      if (left_q == 3'd0) begin
        as_dstrb_o <= 1'b0;
      end else begin
        as_data_o <= pay_q[7:0];
        pay_q     <= pay_q >> 8;
        left_q    <= left_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/as_wb_bridge_burst.sv
// Byte-stream command interface to a Wishbone master with burst support.
// Commands arrive as bytes (cmd, address LSB first, optional count, write
// data LSB first); responses go back as a type byte plus read data.
// Ports:
//   clk, reset (sync, active-high)
//   as_data_i/as_dstrb_i/as_busy_o : inbound byte stream
//   as_data_o/as_dstrb_o/as_busy_i : outbound byte stream
//   wb_*                           : Wishbone master
// Optional feature: define AS_WB_BRIDGE_BURST_TIMEOUT_EN to abort bus
// cycles that see no ack/err within TIMEOUT_CYCLES cycles (response 0xFC).
module as_wb_bridge_burst
  import as_wb_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              as_data_i,
  input  logic                    as_dstrb_i,
  output logic                    as_busy_o,
  output logic [7:0]              as_data_o,
  output logic                    as_dstrb_o,
  input  logic                    as_busy_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [8*ADDR_BYTES-1:0] wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q;
  logic [1:0]    byte_cnt_q;
  logic [8:0]    words_left_q;   // words of the burst not yet completed on the bus
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic          we_q, cyc_q, abort_q;

  logic          in_fire, bus_ack, bus_err, bus_fail, tmo_hit;
  logic          last_adr_byte, last_dat_byte, is_burst;
  logic          tx_load, tx_with_data, tx_done;
  logic [7:0]    tx_type;

  assign as_busy_o     = (state_q == ST_BUS) || (state_q == ST_RESP);
  assign in_fire       = as_dstrb_i && !as_busy_o;
  assign last_adr_byte = (byte_cnt_q == 2'(ADDR_BYTES - 1));
  assign last_dat_byte = (byte_cnt_q == 2'(DATA_BYTES - 1));
  assign is_burst      = (cmd_q == CMD_BURST_READ) || (cmd_q == CMD_BURST_WRITE);
  // err wins over a simultaneous ack
  assign bus_err       = cyc_q && wb_err_i;
  assign bus_ack       = cyc_q && wb_ack_i && !wb_err_i;
  assign bus_fail      = bus_err || tmo_hit;

`ifdef AS_WB_BRIDGE_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || !cyc_q) tmo_cnt_q <= '0;
    else                 tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = cyc_q && !wb_ack_i && !wb_err_i && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CMD;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tx_load      = 1'b0;
    tx_type      = RSP_ACK;
    tx_with_data = 1'b0;
    case (state_q)
      ST_CMD: if (in_fire) begin
        if (is_bus_cmd(as_data_i)) begin
          state_d = ST_ADDR;
        end else if (as_data_i != CMD_NOP) begin
          state_d = ST_RESP;
          tx_load = 1'b1;
          tx_type = (as_data_i == CMD_PING) ? RSP_PING : RSP_CMDERROR;
        end
      end
      ST_ADDR: if (in_fire && last_adr_byte) begin
        if (is_burst)  state_d = ST_COUNT;
        else if (we_q) state_d = ST_WDATA;
        else           state_d = ST_BUS;
      end
      ST_COUNT: if (in_fire) state_d = we_q ? ST_WDATA : ST_BUS;
      ST_WDATA: if (in_fire && last_dat_byte) state_d = ST_BUS;
      ST_BUS: begin
        if (bus_fail) begin
          state_d = ST_RESP;
          tx_load = 1'b1;
          tx_type = bus_err ? RSP_BUSERROR : RSP_TIMEOUT;
        end else if (bus_ack) begin
          if (!we_q) begin
            state_d      = ST_RESP;
            tx_load      = 1'b1;
            tx_with_data = 1'b1;
          end else if (words_left_q == 9'd1) begin
            state_d = ST_RESP;
            tx_load = 1'b1;
          end else begin
            // intermediate burst-write words are not acknowledged individually
            state_d = ST_WDATA;
          end
        end
      end
      ST_RESP: if (tx_done) begin
        if (abort_q)                    state_d = (we_q && words_left_q != 9'd0) ? ST_DRAIN : ST_CMD;
        else if (words_left_q != 9'd0)  state_d = we_q ? ST_WDATA : ST_BUS;
        else                            state_d = ST_CMD;
      end
      ST_DRAIN: if (in_fire && last_dat_byte && words_left_q == 9'd1) state_d = ST_CMD;
      default: state_d = ST_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q        <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      adr_q        <= '0;
      wdat_q       <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      cyc_q <= 1'b0;
      case (state_q)
        ST_CMD: begin
          byte_cnt_q <= '0;
          abort_q    <= 1'b0;
          if (in_fire && is_bus_cmd(as_data_i)) begin
            cmd_q        <= as_data_i;
            we_q         <= (as_data_i == CMD_WRITE) || (as_data_i == CMD_BURST_WRITE);
            words_left_q <= 9'd1;
          end
        end
        ST_ADDR: if (in_fire) begin
          adr_q[8*byte_cnt_q +: 8] <= as_data_i;
          byte_cnt_q <= last_adr_byte ? 2'd0 : byte_cnt_q + 2'd1;
        end
        ST_COUNT: if (in_fire) begin
          words_left_q <= (as_data_i == 8'd0) ? 9'd256 : {1'b0, as_data_i};
        end
        ST_WDATA: if (in_fire) begin
          wdat_q[8*byte_cnt_q +: 8] <= as_data_i;
          byte_cnt_q <= last_dat_byte ? 2'd0 : byte_cnt_q + 2'd1;
        end
        ST_BUS: begin
          // raise cyc/stb one cycle after entry; drop it the cycle after ack/err
          cyc_q <= !(bus_ack || bus_fail);
          if (bus_ack) begin
            adr_q        <= adr_q + 1'b1;
            words_left_q <= words_left_q - 9'd1;
          end
          if (bus_fail) begin
            words_left_q <= words_left_q - 9'd1;
            abort_q      <= 1'b1;
          end
        end
        ST_DRAIN: if (in_fire) begin
          byte_cnt_q <= last_dat_byte ? 2'd0 : byte_cnt_q + 2'd1;
          if (last_dat_byte) words_left_q <= words_left_q - 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;

  as_resp_tx #(.DATA_BYTES(DATA_BYTES)) u_resp_tx (
    .clk          (clk),
    .reset        (reset),
    .load         (tx_load),
    .type_byte    (tx_type),
    .payload      (wb_dat_i),
    .with_payload (tx_with_data),
    .as_data_o    (as_data_o),
    .as_dstrb_o   (as_dstrb_o),
    .as_busy_i    (as_busy_i),
    .done         (tx_done)
  );

endmodule

// File: tb/tb_as_wb_bridge_burst.sv
// Directed self-checking bench for as_wb_bridge_burst (ADDR_BYTES=2,
// DATA_BYTES=2, TIMEOUT_CYCLES=16). The timeout scenario runs only when
// AS_WB_BRIDGE_BURST_TIMEOUT_EN is defined.
module tb_as_wb_bridge_burst;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  as_data_i;
  logic        as_dstrb_i;
  logic        as_busy_o;
  logic [7:0]  as_data_o;
  logic        as_dstrb_o;
  logic        as_busy_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rx_q[$];
  int          bus_cycles = 0;
  int          rx_at_cyc  = 0;
  logic        cyc_prev   = 1'b0;

  as_wb_bridge_burst #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .as_data_i  (as_data_i),
    .as_dstrb_i (as_dstrb_i),
    .as_busy_o  (as_busy_o),
    .as_data_o  (as_data_o),
    .as_dstrb_o (as_dstrb_o),
    .as_busy_i  (as_busy_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  always #5 clk = ~clk;

  // Outbound bytes and bus cycles are recorded on the falling edge; a byte
  // shown with busy low there transfers on the following rising edge.
  always @(negedge clk) begin
    if (!reset && as_dstrb_o && !as_busy_i) rx_q.push_back(as_data_o);
    if (wb_cyc_o && !cyc_prev) bus_cycles++;
    cyc_prev <= wb_cyc_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    as_data_i  = b;
    as_dstrb_i = 1'b1;
    while (as_busy_o !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_accept", as_busy_o, 1'b0);
    @(posedge clk);
  endtask

  task automatic in_idle();
    @(negedge clk);
    as_dstrb_i = 1'b0;
  endtask

  task automatic set_out_busy(input logic v);
    @(posedge clk);
    #1 as_busy_i = v;
  endtask

  task automatic wait_cyc();
    int n = 0;
    @(negedge clk);
    while (wb_cyc_o !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Wishbone slave for one cycle: checks the request, waits lat cycles, then
  // answers with ack and/or err and checks that cyc drops on the next cycle.
  task automatic wb_slave(input string tag, input logic [15:0] exp_adr, input logic exp_we,
                          input logic [15:0] exp_dat, input logic ack, input logic err,
                          input logic [15:0] rdata, input int lat);
    wait_cyc();
    rx_at_cyc = rx_q.size();
    check({tag, "_cyc"}, wb_cyc_o, 1'b1);
    check({tag, "_stb"}, wb_stb_o, 1'b1);
    check({tag, "_adr"}, wb_adr_o, exp_adr);
    check({tag, "_we"}, wb_we_o, exp_we);
    if (exp_we) check({tag, "_dat"}, wb_dat_o, exp_dat);
    repeat (lat) @(negedge clk);
    check({tag, "_adr_hold"}, wb_adr_o, exp_adr);
    check({tag, "_stb_hold"}, wb_stb_o, 1'b1);
    wb_ack_i = ack;
    wb_err_i = err;
    wb_dat_i = rdata;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    check({tag, "_cyc_drop"}, wb_cyc_o, 1'b0);
  endtask

  // Waits for n outbound bytes (first byte in exp[7:0]), checks no extra
  // byte follows, then clears the capture queue.
  task automatic expect_rx(input string tag, input int n, input logic [31:0] exp);
    int k = 0;
    logic [31:0] e;
    logic [7:0]  got;
    e = exp;
    while (rx_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), got, e[8*i +: 8]);
    end
    rx_q.delete();
  endtask

  initial begin
    reset      = 1'b1;
    as_data_i  = 8'h00;
    as_dstrb_i = 1'b0;
    as_busy_i  = 1'b0;
    wb_dat_i   = 16'h0000;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_dstrb", as_dstrb_o, 1'b0);
    check("rst_as_data", as_data_o, 8'h00);
    check("rst_adr", wb_adr_o, 16'h0000);
    check("rst_dat", wb_dat_o, 16'h0000);
    check("rst_busy", as_busy_o, 1'b0);
    reset = 1'b0;

    // NOP is swallowed, PING answers 08 with no bus activity
    bus_cycles = 0;
    send_byte(8'h00);
    send_byte(8'h08);
    in_idle();
    expect_rx("ping", 1, 32'h08);
    check("ping_no_bus", bus_cycles, 0);

    // Unknown code -> CMDERROR, back in CMD
    send_byte(8'h07);
    in_idle();
    expect_rx("cmderr", 1, 32'hFD);
    check("cmderr_idle", as_busy_o, 1'b0);

    // Single READ 0x1234 -> 01 EF BE
    send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
    in_idle();
    wb_slave("read", 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 2);
    expect_rx("read", 3, 32'hBEEF01);

    // BURST_WRITE of 2 words at 0xFFFF, address wraps to 0x0000
    bus_cycles = 0;
    send_byte(8'h04); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    in_idle();
    wb_slave("bw0", 16'hFFFF, 1'b1, 16'h2211, 1'b1, 1'b0, 16'h0000, 1);
    check("bw_no_early_ack", rx_q.size(), 0);
    send_byte(8'h33); send_byte(8'h44);
    in_idle();
    wb_slave("bw1", 16'h0000, 1'b1, 16'h4433, 1'b1, 1'b0, 16'h0000, 0);
    expect_rx("bw", 1, 32'h01);
    check("bw_cycles", bus_cycles, 2);

    // BURST_READ of 3 words at 0x1000, err on the 2nd -> 01 A5 5A FE
    bus_cycles = 0;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    in_idle();
    wb_slave("br0", 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5AA5, 0);
    wb_slave("br1", 16'h1001, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1);
    check("br_resp_before_next", rx_at_cyc, 3);
    expect_rx("br", 4, 32'hFE5AA501);
    check("br_cycles", bus_cycles, 2);
    check("br_idle", as_busy_o, 1'b0);

    // ack and err together: err wins
    send_byte(8'h03); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h01);
    in_idle();
    wb_slave("both", 16'hCDAB, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1111, 0);
    expect_rx("both", 1, 32'hFE);

    // BURST_WRITE error on word 1 of 2: FE, remaining payload drained, then PING works
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    in_idle();
    wb_slave("bwe", 16'h2000, 1'b1, 16'hBBAA, 1'b0, 1'b1, 16'h0000, 0);
    expect_rx("bwe", 1, 32'hFE);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h08);
    in_idle();
    expect_rx("drain", 1, 32'h08);

    // Outbound backpressure holds the response
    set_out_busy(1'b1);
    send_byte(8'h01); send_byte(8'h78); send_byte(8'h56);
    in_idle();
    wb_slave("bp", 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1357, 0);
    repeat (5) @(negedge clk);
    check("bp_dstrb", as_dstrb_o, 1'b1);
    check("bp_data", as_data_o, 8'h01);
    check("bp_held", rx_q.size(), 0);
    set_out_busy(1'b0);
    expect_rx("bp", 3, 32'h135701);

    // Reset during BUS drops cyc next cycle, no response
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
    in_idle();
    wait_cyc();
    check("rb_cyc_up", wb_cyc_o, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rb_cyc_drop", wb_cyc_o, 1'b0);
    check("rb_stb_drop", wb_stb_o, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rb_no_resp", rx_q.size(), 0);
    send_byte(8'h08);
    in_idle();
    expect_rx("rb_ping", 1, 32'h08);

`ifdef AS_WB_BRIDGE_BURST_TIMEOUT_EN
    // Silent slave: cyc held 16 cycles then TIMEOUT
    begin
      int n = 0;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h40);
      in_idle();
      wait_cyc();
      while (wb_cyc_o === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("tmo_len", n, 16);
      expect_rx("tmo", 1, 32'hFC);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
